// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between N producers, the arbiter and one FIFO write port.
// master = arbiter view, slave = producers/FIFO view.
interface fifo_wr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]         req_valid;
  logic [N-1:0][W-1:0]  req_data;
  logic [N-1:0]         req_ready;
  logic                 fifo_full;
  logic                 fifo_wrt_en;
  logic [W-1:0]         fifo_data;
  logic                 grant_valid;
  logic [IW-1:0]        grant_id;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wrt_en, fifo_data, grant_valid, grant_id
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wrt_en, fifo_data, grant_valid, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers; a grant is
// held for up to BURST beats, stalls on fifo_full and releases early on req drop.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 32,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [IW-1:0] winner, nxt_ptr, idx;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;
  logic          found, beat, last;

  // Search upward from rr_ptr, wrapping at N (N need not be a power of two).
  always_comb begin
    winner = rr_ptr_q;
    found  = 1'b0;
    idx    = rr_ptr_q;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
      idx = (idx == IW'(N-1)) ? '0 : idx + 1'b1;
    end
  end

  assign nxt_ptr = (owner_q == IW'(N-1)) ? '0 : owner_q + 1'b1;
  assign beat    = (state_q == LOCKED) && bus.req_valid[owner_q] && !bus.fifo_full;
  assign last    = (beat_cnt_q == BW'(BURST-1));

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    if (state_q == IDLE) begin
      if (|bus.req_valid) begin
        state_d    = LOCKED;
        owner_d    = winner;
        beat_cnt_d = '0;
      end
    end else if (beat ? last : !bus.req_valid[owner_q]) begin
      // Burst finished or owner went quiet; full with valid still set just holds.
      state_d  = IDLE;
      rr_ptr_d = nxt_ptr;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    bus.req_ready   = '0;
    bus.fifo_wrt_en = 1'b0;
    bus.fifo_data   = '0;
    bus.grant_valid = 1'b0;
    bus.grant_id    = '0;
    if (state_q == LOCKED) begin
      bus.grant_valid        = 1'b1;
      bus.grant_id           = owner_q;
      bus.req_ready[owner_q] = !bus.fifo_full;
      bus.fifo_data          = bus.req_data[owner_q];
      bus.fifo_wrt_en        = beat;
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: u4 (N=4,BURST=4), u2 (N=4,BURST=2), u3 (N=3,BURST=4) with
// simple counting producers and a queue standing in for each FIFO.
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.N(4), .W(8)) b4 ();
  fifo_wr_arbiter_if #(.N(4), .W(8)) b2 ();
  fifo_wr_arbiter_if #(.N(3), .W(8)) b3 ();

  fifo_wr_arbiter #(.N(4), .W(8), .BURST(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  fifo_wr_arbiter #(.N(4), .W(8), .BURST(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  fifo_wr_arbiter #(.N(3), .W(8), .BURST(4)) u3 (.clk(clk), .rst(rst), .bus(b3));

  int n_assert = 0;
  int n_fail   = 0;

  int         cnt4[4], lim4[4], cnt2[4], lim2[4], cnt3[3], lim3[3];
  logic [7:0] base4[4], base2[4], base3[3];
  logic       full4;
  logic [7:0] q4[$], q2[$], q3[$];
  int         o2[$], o3[$];
  logic [31:0] tr4;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Producer i offers base+cnt while cnt < lim.
  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      b4.req_valid[i] = cnt4[i] < lim4[i];
      b4.req_data[i]  = base4[i] + 8'(cnt4[i]);
      b2.req_valid[i] = cnt2[i] < lim2[i];
      b2.req_data[i]  = base2[i] + 8'(cnt2[i]);
    end
    for (int i = 0; i < 3; i++) begin
      b3.req_valid[i] = cnt3[i] < lim3[i];
      b3.req_data[i]  = base3[i] + 8'(cnt3[i]);
    end
    b4.fifo_full = full4;
    b2.fifo_full = 1'b0;
    b3.fifo_full = 1'b0;
  endtask

  task automatic look();
    drive();
    #1;
  endtask

  task automatic step();
    logic [3:0] c4, c2;
    logic [2:0] c3;
    look();
    c4 = b4.req_valid & b4.req_ready;
    c2 = b2.req_valid & b2.req_ready;
    c3 = b3.req_valid & b3.req_ready;
    if (b4.fifo_wrt_en) q4.push_back(b4.fifo_data);
    tr4 = {tr4[30:0], b4.fifo_wrt_en};
    if (b2.fifo_wrt_en) begin q2.push_back(b2.fifo_data); o2.push_back(int'(b2.grant_id)); end
    if (b3.fifo_wrt_en) begin q3.push_back(b3.fifo_data); o3.push_back(int'(b3.grant_id)); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (c4[i]) cnt4[i]++;
      if (c2[i]) cnt2[i]++;
    end
    for (int i = 0; i < 3; i++) if (c3[i]) cnt3[i]++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      cnt4[i] = 0; lim4[i] = 0; base4[i] = 8'h00;
      cnt2[i] = 0; lim2[i] = 0; base2[i] = 8'(i * 16);
    end
    for (int i = 0; i < 3; i++) begin cnt3[i] = 0; lim3[i] = 0; base3[i] = 8'h00; end
    full4 = 1'b0;
    tr4   = '0;

    // Reset state
    look();
    chk("rst_gv",    32'(b4.grant_valid), 0);
    chk("rst_wr",    32'(b4.fifo_wrt_en), 0);
    chk("rst_ready", 32'(b4.req_ready),   0);
    chk("rst_data",  32'(b4.fifo_data),   0);
    chk("rst_gid",   32'(b4.grant_id),    0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // 1: single requester 2, ten words A0..A9
    base4[2] = 8'hA0; lim4[2] = 10;
    look();
    chk("t1_idle_gv", 32'(b4.grant_valid), 0);
    step();
    tr4 = '0;
    look();
    chk("t1_gv",    32'(b4.grant_valid), 1);
    chk("t1_gid",   32'(b4.grant_id),    2);
    chk("t1_wr",    32'(b4.fifo_wrt_en), 1);
    chk("t1_data",  32'(b4.fifo_data),   32'hA0);
    chk("t1_ready", 32'(b4.req_ready),   32'b0100);
    repeat (13) step();
    chk("t1_trace", tr4, 32'h1EF6);
    chk("t1_size",  32'(q4.size()), 10);
    for (int j = 0; j < 10; j++) chk($sformatf("t1_q%0d", j), 32'(q4[j]), 32'hA0 + j);

    // 3: early release by requester 1 (rr_ptr=3 so 1 wins first)
    base4[1] = 8'h10; lim4[1] = 1; lim4[2] = 20;
    look();
    chk("t3_idle_gv", 32'(b4.grant_valid), 0);
    step();
    look();
    chk("t3_gid1",  32'(b4.grant_id),    1);
    chk("t3_wr1",   32'(b4.fifo_wrt_en), 1);
    chk("t3_data1", 32'(b4.fifo_data),   32'h10);
    step();
    look();
    chk("t3_rel_wr",  32'(b4.fifo_wrt_en), 0);
    chk("t3_rel_gid", 32'(b4.grant_id),    1);
    step();
    look();
    chk("t3_bubble_gv", 32'(b4.grant_valid), 0);
    lim4[1] = 5;
    step();
    look();
    chk("t3_next_gid",  32'(b4.grant_id),  2);
    chk("t3_next_data", 32'(b4.fifo_data), 32'hAA);
    step();

    // 4: backpressure at beat_cnt=1 for 5 cycles
    full4 = 1'b1;
    q4.delete();
    tr4 = '0;
    look();
    chk("t4_ready", 32'(b4.req_ready), 0);
    chk("t4_gid",   32'(b4.grant_id),  2);
    chk("t4_data",  32'(b4.fifo_data), 32'hAB);
    for (int k = 0; k < 5; k++) begin
      look();
      chk($sformatf("t4_hold_wr%0d", k),  32'(b4.fifo_wrt_en), 0);
      chk($sformatf("t4_hold_gv%0d", k),  32'(b4.grant_valid), 1);
      step();
    end
    full4 = 1'b0;
    repeat (4) step();
    chk("t4_trace", tr4, 32'h00E);
    chk("t4_size",  32'(q4.size()), 3);
    for (int j = 0; j < 3; j++) chk($sformatf("t4_q%0d", j), 32'(q4[j]), 32'hAB + j);

    // 5: reset after two beats of requester 1
    look();
    chk("t5_gid",  32'(b4.grant_id),  1);
    chk("t5_data", 32'(b4.fifo_data), 32'h11);
    step();
    step();
    rst = 1'b1;
    look();
    chk("t5_rst_gv",    32'(b4.grant_valid), 0);
    chk("t5_rst_wr",    32'(b4.fifo_wrt_en), 0);
    chk("t5_rst_ready", 32'(b4.req_ready),   0);
    chk("t5_rst_gid",   32'(b4.grant_id),    0);
    chk("t5_rst_data",  32'(b4.fifo_data),   0);
    step();
    rst = 1'b0;
    lim4[2] = cnt4[2]; base4[3] = 8'h30; lim4[3] = 8;
    look();
    chk("t5_req",     32'(b4.req_valid),   32'b1010);
    chk("t5_idle_gv", 32'(b4.grant_valid), 0);
    step();
    look();
    chk("t5_gid_after", 32'(b4.grant_id),  1);
    chk("t5_data_after", 32'(b4.fifo_data), 32'h13);

    // 2: all four continuous, BURST=2
    for (int i = 0; i < 4; i++) lim2[i] = 100;
    repeat (24) step();
    chk("t2_size", 32'(q2.size()), 16);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("t2_gid%0d", j), 32'(o2[j]), 32'((j / 2) % 4));
      chk($sformatf("t2_q%0d", j),   32'(q2[j]), 32'(((j / 2) % 4) * 16 + (j / 8) * 2 + (j % 2)));
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t2_cnt%0d", i), 32'(cnt2[i]), 4);

    // 6: N=3, requesters 2 then 0
    base3[2] = 8'h20; lim3[2] = 100;
    look();
    chk("t6_idle_gv", 32'(b3.grant_valid), 0);
    step();
    lim3[0] = 100;
    repeat (19) step();
    chk("t6_size", 32'(q3.size()), 16);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("t6_gid%0d", j), 32'(o3[j]), ((j / 4) % 2 == 0) ? 2 : 0);
      chk($sformatf("t6_q%0d", j), 32'(q3[j]),
          32'((((j / 4) % 2 == 0) ? 32 : 0) + (j / 8) * 4 + (j % 4)));
    end
    look();
    chk("t6_bubble_gv", 32'(b3.grant_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
